// File: rtl/serial_pkg.sv
// Shared constants for the serial frame transmitter: FSM state
// encodings, default word width and a constant clog2 helper.
package serial_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_GAP    = 2'd3;

    localparam int DEF_DATA_W = 4;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// Loadable up-counter with terminal-count flag.
// Ports: clk, rst (sync, active-high), load/load_val (load wins over
// en), en (increment), term (terminal value), count, tc (count==term).
module serial_bit_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic [W-1:0] count,
    output logic         tc
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == term);

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter, LSB first, optional even parity
// bit (macro SERIAL_PARITY_EN) and GAP_CYCLES idle cycles per frame.
// Ports: clk, rst (sync, active-high), load_valid/load_data/load_ready
// handshake, sout/sout_valid serial output, frame_done last-bit pulse.
module serial_frame_tx
    import serial_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              sout,
    output logic              sout_valid,
    output logic              frame_done
);

    localparam int CW = clog2(DATA_W + 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(DATA_W - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
    localparam logic [1:0] ST_AFTER =
        (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
`ifndef SERIAL_PARITY_EN
    localparam logic [CW-1:0] BIT_PENULT = CW'(DATA_W - 2);
`endif

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              sout_q, sout_d;
    logic              sout_valid_q, sout_valid_d;
    logic              frame_done_q, frame_done_d;
`ifdef SERIAL_PARITY_EN
    logic              par_q, par_d;
`endif

    logic          bit_load, bit_en, bit_tc;
    logic [CW-1:0] bit_cnt;
    logic          gap_load, gap_en, gap_tc;
    logic [3:0]    gap_cnt;
    logic          unused_gap_cnt;

    serial_bit_counter #(.W(CW)) u_bit_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (bit_load),
        .load_val ('0),
        .en       (bit_en),
        .term     (BIT_LAST),
        .count    (bit_cnt),
        .tc       (bit_tc)
    );

    serial_bit_counter #(.W(4)) u_gap_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load),
        .load_val ('0),
        .en       (gap_en),
        .term     (GAP_LAST),
        .count    (gap_cnt),
        .tc       (gap_tc)
    );

    // Only the terminal flag matters for the gap.
    assign unused_gap_cnt = ^gap_cnt;

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        bit_load = 1'b0;
        bit_en   = 1'b0;
        gap_load = 1'b0;
        gap_en   = 1'b0;
`ifdef SERIAL_PARITY_EN
        par_d    = par_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (load_valid) begin
                    state_d  = ST_SHIFT;
                    buf_d    = load_data;
                    bit_load = 1'b1;
`ifdef SERIAL_PARITY_EN
                    par_d    = ^load_data;
`endif
                end
            end
            ST_SHIFT: begin
                buf_d  = buf_q >> 1;
                bit_en = 1'b1;
                if (bit_tc) begin
`ifdef SERIAL_PARITY_EN
                    state_d  = ST_PARITY;
`else
                    state_d  = ST_AFTER;
                    gap_load = 1'b1;
`endif
                end
            end
`ifdef SERIAL_PARITY_EN
            ST_PARITY: begin
                state_d  = ST_AFTER;
                gap_load = 1'b1;
            end
`endif
            ST_GAP: begin
                gap_en = 1'b1;
                if (gap_tc) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered, so they are derived from the
        // next state: buf_d[0] is the bit shown next cycle.
        sout_valid_d = (state_d == ST_SHIFT);
        sout_d       = (state_d == ST_SHIFT) ? buf_d[0] : 1'b0;
`ifdef SERIAL_PARITY_EN
        if (state_d == ST_PARITY) begin
            sout_valid_d = 1'b1;
            sout_d       = par_d;
        end
        frame_done_d = (state_d == ST_PARITY) &&
                       (state_q == ST_SHIFT);
`else
        // Penultimate bit now means the last bit shows next cycle.
        frame_done_d = (state_q == ST_SHIFT) &&
                       (bit_cnt == BIT_PENULT);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            buf_q        <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef SERIAL_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            frame_done_q <= frame_done_d;
`ifdef SERIAL_PARITY_EN
            par_q        <= par_d;
`endif
        end
    end

    assign load_ready = (state_q == ST_IDLE);
    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Testbench for serial_frame_tx: directed and random frames against a
// bit-list model; second instance exercises GAP_CYCLES=3.
`timescale 1ns/1ps
module tb_serial_frame_tx;

    localparam int DW   = 4;
    localparam int GAPS = 3;
`ifdef SERIAL_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FL = DW + P;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_valid;
    logic [3:0] load_data;
    logic       load_ready, sout, sout_valid, frame_done;
    logic       g_valid;
    logic [3:0] g_data;
    logic       g_ready, g_sout, g_sout_valid, g_frame_done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic [3:0] sr = 4'h0;

    serial_frame_tx #(.DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .frame_done (frame_done)
    );

    serial_frame_tx #(.DATA_W(DW), .GAP_CYCLES(GAPS)) dut_g (
        .clk        (clk),
        .rst        (rst),
        .load_valid (g_valid),
        .load_data  (g_data),
        .load_ready (g_ready),
        .sout       (g_sout),
        .sout_valid (g_sout_valid),
        .frame_done (g_frame_done)
    );

    always #5 clk = ~clk;

    // Downstream 4-bit register: shifts right, inserts at MSB.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        sr  <= {sout, sr[3:1]};
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    // Frame bit k: data LSB first, then parity = odd count of ones.
    function automatic logic exp_bit(input logic [3:0] w, input int k);
        if (k < DW) return w[k];
        return 1'(($countones(w) % 2) == 1);
    endfunction

    task automatic run_frame(input logic [3:0] w,
                             input logic [3:0] w_mid);
        chk("idle_ready", 32'(load_ready), 1);
        load_valid = 1'b1;
        load_data  = w;
        @(negedge clk);
        load_valid = 1'b0;
        load_data  = w_mid;
        for (int k = 0; k < FL; k++) begin
            chk($sformatf("bit%0d_w%0h", k, w), 32'(sout),
                32'(exp_bit(w, k)));
            chk("bit_valid", 32'(sout_valid), 1);
            chk("bit_done", 32'(frame_done), 32'(k == FL - 1));
            chk("busy_ready", 32'(load_ready), 0);
            @(negedge clk);
        end
        chk("post_valid", 32'(sout_valid), 0);
        chk("post_sout", 32'(sout), 0);
        chk("post_done", 32'(frame_done), 0);
`ifndef SERIAL_PARITY_EN
        chk("downstream", 32'(sr), 32'(w));
`endif
    endtask

    initial begin
        logic q[$];
        logic [3:0] w, m;
        int t0, guard;

        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = 4'h0;
        g_valid    = 1'b0;
        g_data     = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_sout", 32'(sout), 0);
        chk("rst_valid", 32'(sout_valid), 0);
        chk("rst_done", 32'(frame_done), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(load_ready), 1);

        run_frame(4'b1011, 4'b1011);
        run_frame(4'hF, 4'h0);
        run_frame(4'b0111, 4'(~4'b0111));

        // load_valid held high: A then 3.
        chk("b2b_ready", 32'(load_ready), 1);
        load_valid = 1'b1;
        load_data  = 4'hA;
        t0 = cyc;
        @(negedge clk);
        load_data = 4'h3;
        guard = 0;
        while (!load_ready && guard < 40) begin
            if (sout_valid) q.push_back(sout);
            @(negedge clk);
            guard++;
        end
        chk("b2b_period", 32'(cyc - t0), 32'(FL + 1));
        @(negedge clk);
        load_valid = 1'b0;
        for (int k = 0; k < FL; k++) begin
            if (sout_valid) q.push_back(sout);
            @(negedge clk);
        end
        chk("b2b_count", 32'(q.size()), 32'(2 * FL));
        for (int k = 0; k < 2 * FL; k++) begin
            chk($sformatf("b2b_bit%0d", k), 32'(q[k]),
                32'(exp_bit((k < FL) ? 4'hA : 4'h3, k % FL)));
        end

        for (int i = 0; i < 12; i++) begin
            w = 4'($urandom);
            m = 4'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_frame(w, m);
        end

        // Reset after two bits; then rst together with load_valid.
        w = 4'($urandom);
        chk("ab_ready", 32'(load_ready), 1);
        load_valid = 1'b1;
        load_data  = w;
        @(negedge clk);
        load_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("ab_bit", 32'(sout), 32'(exp_bit(w, k)));
            chk("ab_done", 32'(frame_done), 0);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("ab_valid", 32'(sout_valid), 0);
        chk("ab_sout", 32'(sout), 0);
        chk("ab_done2", 32'(frame_done), 0);
        chk("ab_ready2", 32'(load_ready), 1);
        load_valid = 1'b1;
        load_data  = 4'hF;
        @(negedge clk);
        chk("rstld_ready", 32'(load_ready), 1);
        chk("rstld_valid", 32'(sout_valid), 0);
        rst        = 1'b0;
        load_valid = 1'b0;
        @(negedge clk);
        chk("rstld_idle", 32'(sout_valid), 0);
        chk("rstld_done", 32'(frame_done), 0);

        // Gap instance, load_valid held high across two frames.
        g_valid = 1'b1;
        for (int r = 0; r < 2; r++) begin
            w = 4'($urandom);
            chk("g_ready0", 32'(g_ready), 1);
            g_data = w;
            t0 = cyc;
            @(negedge clk);
            g_data = ~w;
            if (r == 1) g_valid = 1'b0;
            for (int k = 0; k < FL; k++) begin
                chk("g_bit", 32'(g_sout), 32'(exp_bit(w, k)));
                chk("g_bvalid", 32'(g_sout_valid), 1);
                chk("g_done", 32'(g_frame_done), 32'(k == FL - 1));
                @(negedge clk);
            end
            for (int k = 0; k < GAPS; k++) begin
                chk("g_gvalid", 32'(g_sout_valid), 0);
                chk("g_gsout", 32'(g_sout), 0);
                chk("g_gready", 32'(g_ready), 0);
                @(negedge clk);
            end
            chk("g_ready1", 32'(g_ready), 1);
            chk("g_period", 32'(cyc - t0), 32'(FL + GAPS + 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
